// File: rtl/lfsr_rng_gen.sv
// Fibonacci LFSR random-number source: emits a registered WIDTH-bit sample plus a one-hot decode of its low bits.
// Latency: first sample is valid SHIFTS_PER_SAMPLE enabled cycles after reset release or a seed load.
// Backpressure: a pending sample stalls the LFSR at its terminal shift until rnd_ready; optional sample counter under LFSR_SAMPLE_CNT_EN.
module lfsr_rng_gen #(
    parameter int                 WIDTH             = 13,
    parameter logic [WIDTH-1:0]   TAPS              = 13'h100D,
    parameter logic [WIDTH-1:0]   SEED              = 13'h000F,
    parameter int                 SHIFTS_PER_SAMPLE = 13,
    parameter int                 DECODE_BITS       = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        seed_load,
    input  logic [WIDTH-1:0]            seed_in,
    output logic                        rnd_valid,
    input  logic                        rnd_ready,
    output logic [WIDTH-1:0]            rnd,
    output logic [2**DECODE_BITS-1:0]   onehot,
    output logic [WIDTH-1:0]            lfsr_state
`ifdef LFSR_SAMPLE_CNT_EN
    ,
    output logic [15:0]                 sample_cnt
`endif
);

    localparam int         OH_W = 2**DECODE_BITS;
    localparam logic [7:0] LAST = 8'(SHIFTS_PER_SAMPLE - 1);

    typedef enum logic {RUN, STALL} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [WIDTH-1:0]  state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  rnd_q, rnd_d;
    logic [OH_W-1:0]   onehot_q, onehot_d;
    logic              valid_q, valid_d;

    logic              fb;
    logic [WIDTH-1:0]  next_w;
    logic              at_term;
    logic              xfer;
    logic              shift_ok;

    // Feedback and the shifted candidate state.
    assign fb      = ^(state_q & TAPS);
    assign next_w  = {state_q[WIDTH-2:0], fb};
    assign at_term = (cnt_q == LAST);
    assign xfer    = valid_q && rnd_ready;

    // Next-state, stall decision, capture and handshake; seed load overrides everything.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        shift_ok = 1'b0;

        case (fsm_q)
            RUN: begin
                // Terminal shift would overwrite an unconsumed sample: park here.
                shift_ok = enable && !(at_term && valid_q && !rnd_ready);
                if (at_term && valid_q && !rnd_ready) begin
                    fsm_d = STALL;
                end
            end
            STALL: begin
                // Already parked at the terminal count with a pending sample.
                shift_ok = enable && rnd_ready;
                if (rnd_ready) begin
                    fsm_d = RUN;
                end
            end
            default: begin
                fsm_d = RUN;
            end
        endcase

        if (seed_load) begin
            // Zero seed would lock the LFSR up, so fall back to SEED.
            state_d = (seed_in == '0) ? SEED : seed_in;
            cnt_d   = 8'd0;
            valid_d = 1'b0;
            fsm_d   = RUN;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
            end
            if (shift_ok) begin
                state_d = next_w;
                if (at_term) begin
                    // Capture overrides a same-cycle transfer: back-to-back samples.
                    rnd_d    = next_w;
                    onehot_d = OH_W'(1) << next_w[DECODE_BITS-1:0];
                    valid_d  = 1'b1;
                    cnt_d    = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q    <= RUN;
            state_q  <= SEED;
            cnt_q    <= 8'd0;
            rnd_q    <= '0;
            onehot_q <= OH_W'(1);
            valid_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign rnd_valid  = valid_q;
    assign rnd        = rnd_q;
    assign onehot     = onehot_q;
    assign lfsr_state = state_q;

`ifdef LFSR_SAMPLE_CNT_EN
    logic [15:0] scnt_q, scnt_d;

    // Saturating count of accepted samples, cleared on reseed.
    always_comb begin
        scnt_d = scnt_q;
        if (seed_load) begin
            scnt_d = 16'd0;
        end else if (xfer && (scnt_q != 16'hFFFF)) begin
            scnt_d = scnt_q + 16'd1;
        end
    end

    // Sample counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt_q <= 16'd0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign sample_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Bench for lfsr_rng_gen: default 13-bit instance checked every cycle against a behavioural model,
// plus an 8-bit single-shift instance exercising the full 255-state period.
module tb_lfsr_rng_gen;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Default instance
    logic        enable = 1'b0, seed_load = 1'b0, rnd_ready = 1'b0;
    logic [12:0] seed_in = 13'h0;
    logic        rnd_valid;
    logic [12:0] rnd, lfsr_state;
    logic [7:0]  onehot;
    // 8-bit instance
    logic        en2 = 1'b0, rdy2 = 1'b0;
    logic        rv2;
    logic [7:0]  rnd2, st2, oh2;
`ifdef LFSR_SAMPLE_CNT_EN
    logic [15:0] sample_cnt, sample_cnt2;
`endif

    lfsr_rng_gen dut (
        .clock(clock), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd), .onehot(onehot), .lfsr_state(lfsr_state)
`ifdef LFSR_SAMPLE_CNT_EN
        , .sample_cnt(sample_cnt)
`endif
    );

    lfsr_rng_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .SHIFTS_PER_SAMPLE(1), .DECODE_BITS(3)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .seed_load(1'b0), .seed_in(8'h00),
        .rnd_valid(rv2), .rnd_ready(rdy2), .rnd(rnd2), .onehot(oh2), .lfsr_state(st2)
`ifdef LFSR_SAMPLE_CNT_EN
        , .sample_cnt(sample_cnt2)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One LFSR step: shift left, inject parity of tapped bits.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input logic [31:0] taps, input int w);
        logic [31:0] fb;
        fb = 32'($countones(s & taps) % 2);
        return ((s << 1) | fb) & ((32'd1 << w) - 32'd1);
    endfunction

    // Behavioural model of the default instance.
    logic [12:0] m_state, m_rnd;
    logic [7:0]  m_oh;
    logic        m_valid;
    int          m_shifts;
    logic [15:0] m_scnt;

    always @(posedge clock or posedge reset) begin
        logic took;
        if (reset) begin
            m_state = 13'h000F; m_rnd = 13'h0; m_oh = 8'h01; m_valid = 1'b0; m_shifts = 0; m_scnt = 16'h0;
        end else begin
            took = m_valid && rnd_ready;
            if (seed_load) begin
                m_state  = (seed_in == 13'h0) ? 13'h000F : seed_in;
                m_shifts = 0; m_valid = 1'b0; m_scnt = 16'h0;
            end else begin
                if (took) begin
                    m_valid = 1'b0;
                    if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
                end
                // A shift is blocked only when it would complete a sample while one is still unconsumed.
                if (enable && !(m_shifts == 12 && m_valid)) begin
                    m_state  = 13'(lfsr_adv(32'(m_state), 32'h100D, 13));
                    m_shifts = m_shifts + 1;
                    if (m_shifts == 13) begin
                        m_rnd    = m_state;
                        m_oh     = 8'd1 << (m_state % 8);
                        m_valid  = 1'b1;
                        m_shifts = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("state", 32'(lfsr_state), 32'(m_state));
            check("valid", 32'(rnd_valid), 32'(m_valid));
            check("rnd", 32'(rnd), 32'(m_rnd));
            check("onehot", 32'(onehot), 32'(m_oh));
`ifdef LFSR_SAMPLE_CNT_EN
            check("sample_cnt", 32'(sample_cnt), 32'(m_scnt));
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [12:0] held_st, held_rnd;
        logic [7:0]  e;
        int          vcount, zero_hits, early_ret;

        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset values and hold while disabled
        repeat (3) step();
        check("rst_state", 32'(lfsr_state), 32'h000F);
        check("rst_rnd", 32'(rnd), 32'h0);
        check("rst_valid", 32'(rnd_valid), 32'h0);
        check("rst_onehot", 32'(onehot), 32'h01);

        // Single steps and first sample
        enable = 1'b1;
        step(); check("step1", 32'(lfsr_state), 32'h001F);
        step(); check("step2", 32'(lfsr_state), 32'h003F);
        repeat (10) step();
        check("pre_valid", 32'(rnd_valid), 32'h0);
        step();
        check("first_valid", 32'(rnd_valid), 32'h1);
        check("first_rnd", 32'(rnd), 32'h1FF4);
        check("first_onehot", 32'(onehot), 32'h10);

        // Back-pressure: reach terminal count then hold 20 cycles
        repeat (12) step();
        held_st = lfsr_state;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_state", 32'(lfsr_state), 32'(held_st));
            check("stall_rnd", 32'(rnd), 32'h1FF4);
        end
        rnd_ready = 1'b1;
        step();
        check("release_valid", 32'(rnd_valid), 32'h1);

        // Streaming: one valid cycle every 13
        vcount = 0;
        for (int i = 0; i < 52; i++) begin
            step();
            if (rnd_valid) vcount++;
        end
        check("stream_count", 32'(vcount), 32'd4);
        check("stream_last", 32'(rnd_valid), 32'h1);

        // Reseed discards the pending sample even with ready high
        held_rnd = rnd;
        seed_load = 1'b1; seed_in = 13'h0ABC;
        step();
        check("reseed_valid", 32'(rnd_valid), 32'h0);
        check("reseed_state", 32'(lfsr_state), 32'h0ABC);
        check("reseed_rnd_kept", 32'(rnd), 32'(held_rnd));
        seed_in = 13'h0;
        step();
        check("zero_seed", 32'(lfsr_state), 32'h000F);
        seed_load = 1'b0;
        repeat (12) step();
        check("reseed_pre_valid", 32'(rnd_valid), 32'h0);
        step();
        check("reseed_valid2", 32'(rnd_valid), 32'h1);
        check("reseed_rnd2", 32'(rnd), 32'h1FF4);

        // 8-bit instance: one sample per cycle, full period
        en2 = 1'b1; rdy2 = 1'b1;
        e = 8'h01; zero_hits = 0; early_ret = 0;
        for (int k = 1; k <= 255; k++) begin
            step();
            e = 8'(lfsr_adv(32'(e), 32'hB8, 8));
            check("p_state", 32'(st2), 32'(e));
            check("p_rnd", 32'(rnd2), 32'(e));
            check("p_valid", 32'(rv2), 32'h1);
            if (st2 == 8'h00) zero_hits++;
            if (k < 255 && st2 == 8'h01) early_ret++;
        end
        check("period_end", 32'(st2), 32'h01);
        check("no_zero", 32'(zero_hits), 32'd0);
        check("no_early_return", 32'(early_ret), 32'd0);
        en2 = 1'b0;
        step();
        check("p_final_xfer", 32'(rv2), 32'h0);
        check("p_hold", 32'(st2), 32'h01);
`ifdef LFSR_SAMPLE_CNT_EN
        check("p_sample_cnt", 32'(sample_cnt2), 32'd255);
`endif

        // Asynchronous reset mid-sample
        rnd_ready = 1'b0;
        repeat (5) step();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("async_state", 32'(lfsr_state), 32'h000F);
        check("async_valid", 32'(rnd_valid), 32'h0);
        check("async_rnd", 32'(rnd), 32'h0);
        check("async_onehot", 32'(onehot), 32'h01);
        @(posedge clock);
        #1 reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
